// File: rtl/dwt_pkg.sv
// Shared definitions for the 2-D DWT line scheduler.
//   state_t   : scheduler FSM states
//   addr_map  : row-major or transposed buffer address for (pass, line, idx)
//   half_of   : half the line length (size of each coefficient band)
package dwt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LRST,
        FEED,
        DRAIN,
        NEXT
    } state_t;

    // The row pass walks along a row (line-major). The column pass walks down
    // a column, which is the transpose of the same mapping.
    function automatic int unsigned addr_map(input logic        pass,
                                             input int unsigned line,
                                             input int unsigned idx,
                                             input int unsigned size);
        return pass ? (idx * size + line) : (line * size + idx);
    endfunction

    function automatic int unsigned half_of(input int unsigned size);
        return size / 2;
    endfunction

endpackage

// File: rtl/dwt2d_band_writer.sv
// One coefficient band (low or high) of the line scheduler.
// Counts accepted core strobes within a line, drops any strobe beyond
// SIZE/2 and flags it, and forms the buffer write for accepted strobes.
//   sys_clk, sys_rst      : clock, asynchronous active-high reset
//   clear_i               : clears the band counter (core reset cycle)
//   window_i              : strobes are honoured only while this is high
//   strobe_i, data_i      : coefficient strobe and data from the core
//   pass_i, line_i        : current pass and line, for address mapping
//   wr_en_o/addr_o/data_o : buffer write port (combinational from strobe)
//   ovf_o                 : one-cycle pulse when a strobe is dropped
module dwt2d_band_writer
    import dwt_pkg::*;
#(
    parameter int unsigned SIZE   = 32,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned K_BASE = 0
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      clear_i,
    input  logic                      window_i,
    input  logic                      strobe_i,
    input  logic [7:0]                data_i,
    input  logic                      pass_i,
    input  logic [$clog2(SIZE)-1:0]   line_i,
    output logic                      wr_en_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [7:0]                wr_data_o,
    output logic                      ovf_o
);

    localparam int unsigned HALF  = half_of(SIZE);
    localparam int unsigned CNT_W = $clog2(HALF) + 1;

    logic [CNT_W-1:0] idx;
    logic             room;
    logic             accept;

    assign room   = (idx < CNT_W'(HALF));
    assign accept = window_i & strobe_i & room;
    assign ovf_o  = window_i & strobe_i & ~room;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx <= '0;
        end else if (clear_i) begin
            idx <= '0;
        end else if (accept) begin
            idx <= idx + 1'b1;
        end
    end

    // Outputs are forced to zero when no write happens so the port is quiet.
    assign wr_en_o   = accept;
    assign wr_data_o = accept ? data_i : 8'd0;
    assign wr_addr_o = accept ? ADDR_W'(addr_map(pass_i, 32'(line_i), K_BASE + 32'(idx), SIZE))
                              : '0;

endmodule

// File: rtl/dwt2d_line_sched.sv
// Sequences the 1-D two-lift DWT line core over a SIZE x SIZE frame:
// a row pass followed by a column pass over the row-pass result.
//   sys_clk, sys_rst          : clock, asynchronous active-high reset
//   start_i                   : starts a frame (ignored while busy)
//   busy_o, done_o            : frame in progress / frame-complete pulse
//   pass_o                    : 0 = row pass, 1 = column pass
//   rd_en_o, rd_addr_o        : buffer read (1-cycle latency)
//   rd_data_i                 : buffer read data
//   core_rst_o, core_data_o   : core DWT_rst and data_in
//   core_{low,high}_{en,}_i   : coefficient strobes and data from the core
//   wr_{lo,hi}_{en,addr,data}_o : band write ports
//   ovf_o                     : sticky band-overflow flag, cleared on start
module dwt2d_line_sched
    import dwt_pkg::*;
#(
    parameter int unsigned SIZE      = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DRAIN_CYC = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              core_rst_o,
    output logic [7:0]        core_data_o,
    input  logic              core_high_en_i,
    input  logic [7:0]        core_high_i,
    input  logic              core_low_en_i,
    input  logic [7:0]        core_low_i,
    output logic              wr_lo_en_o,
    output logic [ADDR_W-1:0] wr_lo_addr_o,
    output logic [7:0]        wr_lo_data_o,
    output logic              wr_hi_en_o,
    output logic [ADDR_W-1:0] wr_hi_addr_o,
    output logic [7:0]        wr_hi_data_o,
    output logic              ovf_o
);

    localparam int unsigned LINE_W = $clog2(SIZE);
    localparam int unsigned DRN_W  = $clog2(DRAIN_CYC + 1);
    localparam int unsigned HALF   = half_of(SIZE);

    state_t            state, state_nxt;
    logic              pass_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] sample_q;
    logic [DRN_W-1:0]  drain_q;
    logic              rd_en_q;
    logic              done_q;
    logic              ovf_q;

    logic start_ok;
    logic last_line;
    logic window;
    logic lo_ovf, hi_ovf;

    assign start_ok  = (state == IDLE) && start_i;
    assign last_line = (line_q == LINE_W'(SIZE - 1));
    assign window    = (state == FEED) || (state == DRAIN);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i) state_nxt = LRST;
            LRST:  state_nxt = FEED;
            FEED:  if (sample_q == LINE_W'(SIZE - 1)) state_nxt = DRAIN;
            DRAIN: if (drain_q == DRN_W'(DRAIN_CYC - 1)) state_nxt = NEXT;
            NEXT:  state_nxt = (last_line && pass_q) ? IDLE : LRST;
            default: state_nxt = IDLE;
        endcase
    end

    // Sample index runs 0 in LRST through SIZE-1 at the end of FEED and then
    // wraps back to 0, ready for the next line. done_q is registered so that
    // the pulse lands in the first IDLE cycle, when busy_o has already dropped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pass_q   <= 1'b0;
            line_q   <= '0;
            sample_q <= '0;
            drain_q  <= '0;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sample_q <= (state == LRST || state == FEED) ? sample_q + 1'b1 : '0;
            drain_q  <= (state == DRAIN) ? drain_q + 1'b1 : '0;
            rd_en_q  <= rd_en_o;
            done_q   <= (state == NEXT) && last_line && pass_q;

            if (start_ok) begin
                pass_q <= 1'b0;
                line_q <= '0;
            end else if (state == NEXT) begin
                if (!last_line) begin
                    line_q <= line_q + 1'b1;
                end else if (!pass_q) begin
                    pass_q <= 1'b1;
                    line_q <= '0;
                end
            end

            if (start_ok) begin
                ovf_q <= 1'b0;
            end else if (lo_ovf || hi_ovf) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign ovf_o       = ovf_q;
    assign core_rst_o  = (state == LRST);
    assign rd_en_o     = (state == LRST) || (state == FEED);
    assign rd_addr_o   = rd_en_o ? ADDR_W'(addr_map(pass_q, 32'(line_q), 32'(sample_q), SIZE))
                                 : '0;
    assign core_data_o = rd_en_q ? rd_data_i : 8'd0;

    dwt2d_band_writer #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W),
        .K_BASE (0)
    ) u_lo_writer (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clear_i   (core_rst_o),
        .window_i  (window),
        .strobe_i  (core_low_en_i),
        .data_i    (core_low_i),
        .pass_i    (pass_q),
        .line_i    (line_q),
        .wr_en_o   (wr_lo_en_o),
        .wr_addr_o (wr_lo_addr_o),
        .wr_data_o (wr_lo_data_o),
        .ovf_o     (lo_ovf)
    );

    dwt2d_band_writer #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W),
        .K_BASE (HALF)
    ) u_hi_writer (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clear_i   (core_rst_o),
        .window_i  (window),
        .strobe_i  (core_high_en_i),
        .data_i    (core_high_i),
        .pass_i    (pass_q),
        .line_i    (line_q),
        .wr_en_o   (wr_hi_en_o),
        .wr_addr_o (wr_hi_addr_o),
        .wr_data_o (wr_hi_data_o),
        .ovf_o     (hi_ovf)
    );

endmodule

// File: tb/tb_dwt2d_line_sched.sv
// Scoreboard bench for dwt2d_line_sched at SIZE=8, DRAIN_CYC=12.
// A driver plays a stub core with random strobe timing and pushes the
// expected reads and writes into queues; a monitor on the falling edge pops
// and compares whenever the DUT presents a read or a write.
module tb_dwt2d_line_sched;

    localparam int SIZE        = 8;
    localparam int ADDR_W      = 12;
    localparam int DRAIN_CYC   = 12;
    localparam int HALF        = SIZE / 2;
    localparam int LINE_CYC    = SIZE + DRAIN_CYC + 1;
    localparam int FRAME_LINES = 2 * SIZE;

    logic              sys_clk;
    logic              sys_rst;
    logic              start_i;
    logic              busy_o, done_o, pass_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [7:0]        rd_data_i;
    logic              core_rst_o;
    logic [7:0]        core_data_o;
    logic              core_high_en_i, core_low_en_i;
    logic [7:0]        core_high_i, core_low_i;
    logic              wr_lo_en_o, wr_hi_en_o;
    logic [ADDR_W-1:0] wr_lo_addr_o, wr_hi_addr_o;
    logic [7:0]        wr_lo_data_o, wr_hi_data_o;
    logic              ovf_o;

    dwt2d_line_sched #(
        .SIZE      (SIZE),
        .ADDR_W    (ADDR_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_i      (rd_data_i),
        .core_rst_o     (core_rst_o),
        .core_data_o    (core_data_o),
        .core_high_en_i (core_high_en_i),
        .core_high_i    (core_high_i),
        .core_low_en_i  (core_low_en_i),
        .core_low_i     (core_low_i),
        .wr_lo_en_o     (wr_lo_en_o),
        .wr_lo_addr_o   (wr_lo_addr_o),
        .wr_lo_data_o   (wr_lo_data_o),
        .wr_hi_en_o     (wr_hi_en_o),
        .wr_hi_addr_o   (wr_hi_addr_o),
        .wr_hi_data_o   (wr_hi_data_o),
        .ovf_o          (ovf_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int addr;
        int cyc;
        int first;
    } rd_exp_t;

    typedef struct {
        int addr;
        int data;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t lo_q[$];
    wr_exp_t hi_q[$];

    logic [7:0] mem [0:SIZE*SIZE-1];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit mon_en     = 0;
    bit busy_exp   = 0;
    bit done_exp   = 0;
    bit ovf_exp    = 0;
    bit last_rd    = 0;
    int last_rd_addr = 0;

    always @(posedge sys_clk) cyc++;

    // Frame buffer model with a one-cycle read latency.
    always @(posedge sys_clk) begin
        if (rd_en_o) rd_data_i <= mem[int'(rd_addr_o) % (SIZE * SIZE)];
    end

    function automatic int modelAddr(input int pass, input int line, input int idx);
        return (pass != 0) ? idx * SIZE + line : line * SIZE + idx;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: compares every cycle's status outputs and pops the scoreboard
    // queues whenever the DUT presents a read or a band write.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            rd_exp_t r;
            wr_exp_t w;
            checkOutput("busy", busy_o, busy_exp);
            checkOutput("done", done_o, done_exp);
            checkOutput("ovf", ovf_o, ovf_exp);

            if (last_rd) checkOutput("core_data", core_data_o, mem[last_rd_addr]);
            else         checkOutput("core_data_zero", core_data_o, 0);
            last_rd = 0;

            if (rd_en_o || rd_q.size() > 0) begin
                if (rd_q.size() == 0) begin
                    checkOutput("rd_unexpected", rd_en_o, 0);
                end else if (rd_q[0].cyc == cyc || rd_en_o) begin
                    r = rd_q.pop_front();
                    checkOutput("rd_en", rd_en_o, 1);
                    checkOutput("rd_addr", rd_addr_o, r.addr);
                    checkOutput("rd_cycle", cyc, r.cyc);
                    checkOutput("core_rst", core_rst_o, r.first);
                    last_rd = 1;
                    last_rd_addr = r.addr;
                end else begin
                    checkOutput("core_rst_quiet", core_rst_o, 0);
                end
            end else begin
                checkOutput("core_rst_quiet", core_rst_o, 0);
            end

            checkOutput("wr_lo_en", wr_lo_en_o, lo_q.size() > 0);
            if (wr_lo_en_o && lo_q.size() > 0) begin
                w = lo_q.pop_front();
                checkOutput("wr_lo_addr", wr_lo_addr_o, w.addr);
                checkOutput("wr_lo_data", wr_lo_data_o, w.data);
            end
            checkOutput("wr_hi_en", wr_hi_en_o, hi_q.size() > 0);
            if (wr_hi_en_o && hi_q.size() > 0) begin
                w = hi_q.pop_front();
                checkOutput("wr_hi_addr", wr_hi_addr_o, w.addr);
                checkOutput("wr_hi_data", wr_hi_data_o, w.data);
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            core_low_en_i  = ($urandom_range(0, 3) == 0);
            core_high_en_i = ($urandom_range(0, 3) == 0);
            core_low_i     = 8'($urandom);
            core_high_i    = 8'($urandom);
            @(posedge sys_clk);
            #1;
        end
        core_low_en_i  = 1'b0;
        core_high_en_i = 1'b0;
    endtask

    // Runs one full frame as the stub core. Each line gets HALF strobes per
    // band at random cycles inside the feed/drain window (HALF+1 low strobes
    // on the overflow line), plus stray strobes outside the window.
    task automatic applyStimulus(input bit with_ovf, input bit with_mid_start);
        int  ovf_line;
        int  start_k;
        int  c0;
        int  n, p, pass, line, slots;
        int  lo_left, hi_left, lo_done, hi_done;
        bit  ovf_pend;

        ovf_line = with_ovf ? $urandom_range(0, FRAME_LINES - 1) : -1;
        start_k  = with_mid_start ? $urandom_range(3, SIZE * LINE_CYC - 3) : -1;
        ovf_pend = 0;
        lo_left = 0; hi_left = 0; lo_done = 0; hi_done = 0;

        start_i = 1'b1;
        @(posedge sys_clk);
        #1;
        start_i  = 1'b0;
        busy_exp = 1;
        ovf_exp  = 0;
        c0       = cyc;

        for (int ln = 0; ln < FRAME_LINES; ln++) begin
            for (int s = 0; s < SIZE; s++) begin
                rd_exp_t r;
                r.addr  = modelAddr(ln / SIZE, ln % SIZE, s);
                r.cyc   = c0 + ln * LINE_CYC + s;
                r.first = (s == 0);
                rd_q.push_back(r);
            end
        end

        for (int k = 0; k < FRAME_LINES * LINE_CYC; k++) begin
            n    = k / LINE_CYC;
            p    = k % LINE_CYC;
            pass = n / SIZE;
            line = n % SIZE;
            if (p == 0) begin
                lo_left = (n == ovf_line) ? HALF + 1 : HALF;
                hi_left = HALF;
                lo_done = 0;
                hi_done = 0;
            end
            if (ovf_pend) begin
                ovf_exp  = 1;
                ovf_pend = 0;
            end
            start_i        = (k == start_k);
            core_low_en_i  = 1'b0;
            core_high_en_i = 1'b0;
            core_low_i     = 8'($urandom);
            core_high_i    = 8'($urandom);
            if (p >= 1 && p <= LINE_CYC - 2) begin
                slots = LINE_CYC - 1 - p;
                if (lo_left > 0 && (lo_left >= slots || $urandom_range(0, 3) == 0)) begin
                    core_low_en_i = 1'b1;
                    lo_left--;
                    if (lo_done < HALF) begin
                        wr_exp_t w;
                        w.addr = modelAddr(pass, line, lo_done);
                        w.data = core_low_i;
                        lo_q.push_back(w);
                    end else begin
                        ovf_pend = 1;
                    end
                    lo_done++;
                end
                if (hi_left > 0 && (hi_left >= slots || $urandom_range(0, 3) == 0)) begin
                    wr_exp_t w;
                    core_high_en_i = 1'b1;
                    hi_left--;
                    w.addr = modelAddr(pass, line, HALF + hi_done);
                    w.data = core_high_i;
                    hi_q.push_back(w);
                    hi_done++;
                end
            end else begin
                core_low_en_i  = ($urandom_range(0, 2) == 0);
                core_high_en_i = ($urandom_range(0, 2) == 0);
            end
            @(posedge sys_clk);
            #1;
        end

        if (ovf_pend) ovf_exp = 1;
        start_i        = 1'b0;
        core_low_en_i  = 1'b0;
        core_high_en_i = 1'b0;
        busy_exp       = 0;
        done_exp       = 1;
        @(posedge sys_clk);
        #1;
        done_exp = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_pass"}, pass_o, 0);
        checkOutput({tag, "_rd_en"}, rd_en_o, 0);
        checkOutput({tag, "_rd_addr"}, rd_addr_o, 0);
        checkOutput({tag, "_core_rst"}, core_rst_o, 0);
        checkOutput({tag, "_core_data"}, core_data_o, 0);
        checkOutput({tag, "_wr_lo_en"}, wr_lo_en_o, 0);
        checkOutput({tag, "_wr_lo_addr"}, wr_lo_addr_o, 0);
        checkOutput({tag, "_wr_lo_data"}, wr_lo_data_o, 0);
        checkOutput({tag, "_wr_hi_en"}, wr_hi_en_o, 0);
        checkOutput({tag, "_wr_hi_addr"}, wr_hi_addr_o, 0);
        checkOutput({tag, "_wr_hi_data"}, wr_hi_data_o, 0);
        checkOutput({tag, "_ovf"}, ovf_o, 0);
    endtask

    // Starts a frame, strobes the core inside FEED, then hits reset and
    // expects every output to collapse immediately.
    task automatic resetDuringFeed();
        mon_en = 0;
        start_i = 1'b1;
        @(posedge sys_clk);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2;
        checkOutput("feed_rd_en", rd_en_o, 1);
        core_low_en_i  = 1'b1;
        core_high_en_i = 1'b1;
        core_low_i     = 8'hA5;
        core_high_i    = 8'h5A;
        #1;
        checkOutput("feed_wr_lo_en", wr_lo_en_o, 1);
        sys_rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        repeat (2) @(posedge sys_clk);
        #3;
        core_low_en_i  = 1'b0;
        core_high_en_i = 1'b0;
        sys_rst = 1'b0;
        rd_q.delete();
        lo_q.delete();
        hi_q.delete();
        busy_exp = 0;
        done_exp = 0;
        ovf_exp  = 0;
        last_rd  = 0;
        @(posedge sys_clk);
        #1;
        mon_en = 1;
    endtask

    initial begin
        for (int i = 0; i < SIZE * SIZE; i++) mem[i] = 8'($urandom);
        sys_rst        = 1'b1;
        start_i        = 1'b0;
        core_low_en_i  = 1'b0;
        core_high_en_i = 1'b0;
        core_low_i     = 8'd0;
        core_high_i    = 8'd0;
        #12;
        checkAllZero("reset");
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        mon_en = 1;

        idleCycles(5);
        $display("[TB] frame with band overflow and a start pulse while busy");
        applyStimulus(1'b1, 1'b1);
        idleCycles(4);
        $display("[TB] clean frame, overflow flag must clear on start");
        applyStimulus(1'b0, 1'b0);
        idleCycles(3);
        $display("[TB] reset during FEED");
        resetDuringFeed();
        idleCycles(3);
        applyStimulus(1'b0, 1'b1);
        idleCycles(3);

        checkOutput("rd_queue_drained", rd_q.size(), 0);
        checkOutput("lo_queue_drained", lo_q.size(), 0);
        checkOutput("hi_queue_drained", hi_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
